muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply-divide unit, parametrised in data width. It sits in the EX stage beside the single-cycle ALU. The ALU decoder routes funct7 = 0000001 R-type ops here, and the hazard unit stalls on `busy`. The unit executes all eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with a start/busy/done handshake, a pipeline flush, and a fast path for divide-by-zero.

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, start/busy/done handshake with flush and divide-by-zero fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_w(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0] fix_val;

  // Operand conditioning at accept: signedness by op, then magnitude.
  assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
  assign b_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
  assign sign_a   = a_signed & src_a[XLEN-1];
  assign sign_b   = b_signed & src_b[XLEN-1];
  assign abs_a    = neg_x(src_a, sign_a);
  assign abs_b    = neg_x(src_b, sign_b);

  // One multiplier bit per cycle: add into the high half, shift the pair right.
  assign mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? mcand_q : {XLEN{1'b0}})};

  // Restoring step; the remainder always fits XLEN bits once the trial is resolved.
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_q});
  assign div_diff  = div_shift[XLEN-1:0] - mcand_q;

  assign prod_f = neg_w({acc_q, lo_q}, neg_q);

  always_comb begin
    fix_val = prod_f[XLEN-1:0];
    case (op_q)
      3'b000:                 fix_val = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = neg_x(lo_q, neg_q);
      default:                fix_val = neg_x(acc_q, neg_q);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            op_d    = funct3;
            neg_d   = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
            lo_d    = abs_a;
            mcand_d = abs_b;
            acc_d   = '0;
            cnt_d   = '0;
            if (funct3[2] && (src_b == '0)) begin
              state_d  = DONE;
              result_d = funct3[1] ? src_a : '1;
            end else begin
              state_d = CALC;
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], div_ge};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        end
        FIX: begin
          result_d = fix_val;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN = 32): directed plan vectors, randomized
// ops against an arithmetic reference model, flush, mid-op reset and back-to-back.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_muldiv(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] b);
    return (f[2] && b == 0) ? 0 : XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op, scrambles the inputs after accept, and waits (bounded) for done.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_n, output logic first_busy);
    @(negedge clk);
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 0;
    busy_n = busy ? 1 : 0;
    first_busy = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  vf[12];
    logic [31:0] va[12], vb[12], ve[12];
    int lat, bn;
    logic fb;
    vf = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd6, 3'd5, 3'd7};
    va = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
           32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'd100, 32'd100};
    vb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd7, 32'd7};
    ve = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd5, 32'd14, 32'd2};
    for (int i = 0; i < 12; i++) begin
      do_op(vf[i], va[i], vb[i], lat, bn, fb);
      checks++;
      if (result !== ve[i]) begin
        errors++; $display("FAIL directed_result[%0d] got %h want %h", i, result, ve[i]);
      end
      checks++;
      if (lat != ref_latency(vf[i], vb[i])) begin
        errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, ref_latency(vf[i], vb[i]));
      end
      checks++;
      if (bn != ref_latency(vf[i], vb[i])) begin
        errors++; $display("FAIL directed_busy_cycles[%0d] got %0d want %0d", i, bn, ref_latency(vf[i], vb[i]));
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL directed_busy_with_done[%0d] got %b want 0", i, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int lat, bn;
    logic fb;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      exp = ref_muldiv(f, a, b);
      do_op(f, a, b, lat, bn, fb);
      checks++;
      if (result !== exp) begin
        errors++; $display("FAIL random_result f=%0d a=%h b=%h got %h want %h", f, a, b, result, exp);
      end
      checks++;
      if (lat != ref_latency(f, b)) begin
        errors++; $display("FAIL random_latency f=%0d b=%h got %0d want %0d", f, b, lat, ref_latency(f, b));
      end
    end
  endtask

  task automatic test_flush();
    int lat, bn;
    logic fb;
    int seen_done;
    do_op(3'd0, 32'd3, 32'd5, lat, bn, fb);
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_setup got %h want %h", result, 32'd15); end
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", done); end
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_result got %h want %h", result, 32'd15); end
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL flush_quiet got %0d active cycles want 0", seen_done); end
    @(negedge clk);
    flush = 1'b1; start = 1'b1; funct3 = 3'd3; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_accept got busy %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_start_done got %b want 0", done); end
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, lat, bn, fb);
    checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL flush_recover_result got %h want %h", result, 32'h1); end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL flush_recover_latency got %0d want %0d", lat, XLEN + 1); end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    logic fb;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    do_op(3'd0, a1, b1, lat, bn, fb);
    checks++; if (result !== ref_muldiv(3'd0, a1, b1)) begin errors++; $display("FAIL b2b_first got %h want %h", result, ref_muldiv(3'd0, a1, b1)); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_in_done got %b want 1", done); end
    do_op(3'd0, a2, b2, lat, bn, fb);
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got busy %b want 1", fb); end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, XLEN + 1); end
    checks++; if (result !== ref_muldiv(3'd0, a2, b2)) begin errors++; $display("FAIL b2b_second got %h want %h", result, ref_muldiv(3'd0, a2, b2)); end
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    logic fb;
    do_op(3'd0, 32'd6, 32'd7, lat, bn, fb);
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL rstmid_setup got %h want %h", result, 32'd42); end
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy %b done %b want 0 0", busy, done); end
    do_op(3'd4, 32'hFFFF_FF9C, 32'd7, lat, bn, fb);
    checks++; if (result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL rstmid_recover got %h want %h", result, 32'hFFFF_FFF2); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
